io_fifo_port: RTL and testbench
===============================

# io_fifo_port

Parametrised, buffered successor to the keyboard/display peripherals on the tiny16 bus. Incoming characters are captured from an external strobe into an RX FIFO. Outgoing characters are written from the bus into a TX FIFO and drained to the external port with a timed strobe handshake. A status word exposes FIFO state and sticky overflow flags. The block sits on the 1 MHz clock domain beside the bus mux, and its `bus_out` is one bus source.

## Interface
Parameters:
- `DATA_W`, 8, external character width (≤ `BUS_W`).
- `BUS_W`, 16, bus word width.
- `DEPTH`, 4, entries per FIFO; power of two, ≥ 2; `CNT_W` = log2(`DEPTH`)+1; requires 8+`CNT_W` ≤ `BUS_W`.
- `STROBE_CYCLES`, 1, `out_stb` high width in cycles (≥ 1).

Ports:
- `clk` in 1: the single clock. One clock; reset is synchronous and active-high.
- `rst` in 1: synchronous, active-high reset.
- `in` in `DATA_W`: external character.
- `in_stb` in 1: one-cycle pulse; `in` is valid on that cycle.
- `out` out `DATA_W`: character presented to the external device.
- `out_stb` out 1: output strobe.
- `out_ready` in 1: the external device can accept a character.
- `bus_in` in `BUS_W`: bus data; the low `DATA_W` bits are written to TX.
- `wr_en` in 1: push `bus_in` into TX.
- `rd_en` in 1: drive the RX head onto `bus_out` and pop it.
- `stat_en` in 1: drive the status word onto `bus_out`.
- `bus_out` out `BUS_W`: combinational read data; 0 when no enable is active.

## Operation
- RX path: on `in_stb`, `in` is pushed into RX. If RX is full, the character is dropped and `rx_ovf` is set.
- Read: while `rd_en` is high, `bus_out` = zero-extended RX head (0 if RX is empty). The pop happens at the clock edge. `rd_en` on empty: no pointer change, no flag.
- Write: `wr_en` pushes `bus_in[DATA_W-1:0]` into TX. If TX is full, the value is dropped and `tx_ovf` is set.
- Status word bits:
  - [0] `rx_nempty`
  - [1] `tx_full`
  - [2] `rx_ovf`
  - [3] `tx_busy` (state ≠ IDLE)
  - [4] `tx_ovf`
  - [8 +: `CNT_W`] `rx_count`
  - all other bits 0.
- Status read: a cycle with `stat_en` and no `rd_en` clears `rx_ovf`/`tx_ovf` at the edge. If a new overflow occurs on that same edge, the set wins and the flag stays 1.
- `rd_en` and `stat_en` together: `rd_en` wins on `bus_out`; flags are not cleared.
- Simultaneous push and pop on a full FIFO: both take effect, count unchanged, no overflow. Simultaneous push and pop on an empty FIFO: the push takes effect, the read returns 0 (no bypass).
- Pointers wrap modulo `DEPTH`. The extra count bit distinguishes full from empty.
- TX state machine:
  - IDLE: if TX is non-empty and `out_ready`, load `out` ← TX head, pop TX, go to STROBE.
  - STROBE: `out_stb`=1 for `STROBE_CYCLES` cycles, then go to GAP.
  - GAP: `out_stb`=0 for one cycle, then go to IDLE.
  - `out` holds its last value between transfers.
  - `out_ready` is sampled only in IDLE.

## Timing
- Reset values: `out`=0, `out_stb`=0, state IDLE, both FIFOs empty, both ovf flags 0. `bus_out` follows the enables and is 0 when none is active.
- Reset mid-transfer: the strobe is aborted and `out_stb`=0 after the reset edge. Any pending TX entries are discarded.
- RX latency: `in_stb` sampled at edge E makes `rx_nempty`=1 after E. A read is valid in the cycle following E.
- TX latency: `wr_en` sampled at edge E with TX empty, state IDLE and `out_ready`=1 gives `out_stb` rising after edge E+1, held for `STROBE_CYCLES` cycles.
- Back-to-back TX: the minimum period per character is `STROBE_CYCLES`+2 cycles (STROBE, GAP, IDLE).
- All state is updated on the rising edge of `clk`. The only combinational outputs are `bus_out` and the status bits it carries.

## Structure
- Package `io_pkg` holds:
  - status bit index constants (`ST_RX_NEMPTY`, `ST_TX_FULL`, `ST_RX_OVF`, `ST_TX_BUSY`, `ST_TX_OVF`, `ST_RX_CNT_LSB`=8);
  - the TX state enum (IDLE, STROBE, GAP).
- Sub-module `sync_fifo` (parameters `WIDTH`, `DEPTH`; ports push, pop, din, dout, full, empty, count) is instantiated twice, once for RX and once for TX.
- The top holds the flag logic, the TX state machine with its strobe counter, and the `bus_out` mux.

## Test plan
- Reset then `stat_en` → `bus_out`=0x0000. Three `in_stb` with 0x41, 0x42, 0x43 → status 0x0301. Three `rd_en` → 0x0041, 0x0042, 0x0043, then status 0x0000.
- `DEPTH`=4: five `in_stb` (0x10–0x14) → status 0x0405 (`rx_ovf` set, count 4). Reads return 0x10–0x13. A following `stat_en` clears `rx_ovf`.
- `out_ready`=1, `STROBE_CYCLES`=2, `wr_en` 0x55 at edge E → `out`=0x55 and `out_stb` high after E+1 and E+2, low after E+3. `tx_busy` is 1 throughout.
- `out_ready`=0, five writes → `tx_full`=1 and `tx_ovf`=1. Raise `out_ready` → exactly four strobes (first four values) with period `STROBE_CYCLES`+2.
- Full RX with `in_stb` and `rd_en` in the same cycle → count stays 4, `rx_ovf` stays 0, and the oldest entry is returned.
- Assert `rst` during STROBE → after the reset edge `out_stb`=0, `out`=0, status 0x0000, and no further strobes.

Source files
------------

// File: rtl/io_fifo_port_pkg.sv
// Shared definitions for io_fifo_port: status word bit positions and TX strobe states.
package io_pkg;

  localparam int ST_RX_NEMPTY  = 0;
  localparam int ST_TX_FULL    = 1;
  localparam int ST_RX_OVF     = 2;
  localparam int ST_TX_BUSY    = 3;
  localparam int ST_TX_OVF     = 4;
  localparam int ST_RX_CNT_LSB = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    GAP    = 2'd2
  } tx_state_e;

  // Occupancy counter width: one bit more than the pointer so full and empty differ.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/io_fifo_port_if.sv
// Bus-side and external-device signals of io_fifo_port; master drives stimulus, slave is the port.
interface io_fifo_port_if #(
  parameter int DATA_W = 8,
  parameter int BUS_W  = 16
);

  logic [DATA_W-1:0] in;
  logic              in_stb;
  logic [DATA_W-1:0] out;
  logic              out_stb;
  logic              out_ready;
  logic [BUS_W-1:0]  bus_in;
  logic              wr_en;
  logic              rd_en;
  logic              stat_en;
  logic [BUS_W-1:0]  bus_out;

  modport master (
    output in, in_stb, out_ready, bus_in, wr_en, rd_en, stat_en,
    input  out, out_stb, bus_out
  );

  modport slave (
    input  in, in_stb, out_ready, bus_in, wr_en, rd_en, stat_en,
    output out, out_stb, bus_out
  );

endinterface

// File: rtl/io_fifo_port_fifo.sv
// Synchronous FIFO with combinational head; a push is dropped when full unless a pop frees the slot
// on the same edge, and a pop on empty is ignored (no bypass of a same-cycle push).
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Pointers wrap naturally because DEPTH is a power of two.
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
    else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/io_fifo_port.sv
// Buffered character port: external strobe -> RX FIFO -> bus reads; bus writes -> TX FIFO -> timed strobe.
// TX waits for out_ready in IDLE; bus_out is combinational; full FIFOs drop and raise a sticky overflow.
module io_fifo_port
  import io_pkg::*;
#(
  parameter int DATA_W        = 8,
  parameter int BUS_W         = 16,
  parameter int DEPTH         = 4,
  parameter int STROBE_CYCLES = 1
) (
  input logic                clk,
  input logic                rst,
  io_fifo_port_if.slave      io
);

  localparam int CNT_W = cnt_width(DEPTH);
  localparam int SC_W  = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;

  logic [DATA_W-1:0] rx_dout;
  logic              rx_full;
  logic              rx_empty;
  logic [CNT_W-1:0]  rx_count;
  logic [DATA_W-1:0] tx_dout;
  logic              tx_full;
  logic              tx_empty;
  logic [CNT_W-1:0]  tx_count;
  logic              tx_pop;

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (io.in_stb),
    .pop_i   (io.rd_en),
    .din_i   (io.in),
    .dout_o  (rx_dout),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .count_o (rx_count)
  );

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (io.wr_en),
    .pop_i   (tx_pop),
    .din_i   (io.bus_in[DATA_W-1:0]),
    .dout_o  (tx_dout),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .count_o (tx_count)
  );

  if (DATA_W < BUS_W) begin : g_bus_in_hi
    logic unused_bus_in_hi;
    assign unused_bus_in_hi = ^io.bus_in[BUS_W-1:DATA_W];
  end

  // ---------------- sticky overflow flags ----------------
  logic rx_ovf_q, rx_ovf_d;
  logic tx_ovf_q, tx_ovf_d;
  logic rx_ovf_set;
  logic tx_ovf_set;
  logic flag_clr;

  // A drop only happens when the full FIFO is not also being drained on this edge.
  assign rx_ovf_set = io.in_stb && rx_full && !io.rd_en;
  assign tx_ovf_set = io.wr_en && (tx_count == CNT_W'(DEPTH)) && !tx_pop;
  assign flag_clr   = io.stat_en && !io.rd_en;

  always_comb begin
    rx_ovf_d = rx_ovf_set || (rx_ovf_q && !flag_clr);
    tx_ovf_d = tx_ovf_set || (tx_ovf_q && !flag_clr);
  end

  // ---------------- TX strobe state machine ----------------
  tx_state_e         state_q, state_d;
  logic [SC_W-1:0]   stb_cnt_q, stb_cnt_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              out_stb_q, out_stb_d;

  always_comb begin
    state_d   = state_q;
    stb_cnt_d = stb_cnt_q;
    out_d     = out_q;
    tx_pop    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!tx_empty && io.out_ready) begin
          tx_pop    = 1'b1;
          out_d     = tx_dout;
          stb_cnt_d = '0;
          state_d   = STROBE;
        end
      end
      STROBE: begin
        if (stb_cnt_q == SC_W'(STROBE_CYCLES - 1)) state_d = GAP;
        else                                        stb_cnt_d = stb_cnt_q + SC_W'(1);
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // The strobe is a registered decode so the external pin never glitches.
    out_stb_d = (state_d == STROBE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      stb_cnt_q <= '0;
      out_q     <= '0;
      out_stb_q <= 1'b0;
      rx_ovf_q  <= 1'b0;
      tx_ovf_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      stb_cnt_q <= stb_cnt_d;
      out_q     <= out_d;
      out_stb_q <= out_stb_d;
      rx_ovf_q  <= rx_ovf_d;
      tx_ovf_q  <= tx_ovf_d;
    end
  end

  assign io.out     = out_q;
  assign io.out_stb = out_stb_q;

  // ---------------- bus read mux ----------------
  logic [BUS_W-1:0] status_w;
  logic [BUS_W-1:0] rx_head_w;
  logic [BUS_W-1:0] bus_out_w;

  always_comb begin
    status_w                              = '0;
    status_w[ST_RX_NEMPTY]                = !rx_empty;
    status_w[ST_TX_FULL]                  = tx_full;
    status_w[ST_RX_OVF]                   = rx_ovf_q;
    status_w[ST_TX_BUSY]                  = (state_q != IDLE);
    status_w[ST_TX_OVF]                   = tx_ovf_q;
    status_w[ST_RX_CNT_LSB +: CNT_W]      = rx_count;

    rx_head_w = '0;
    if (!rx_empty) rx_head_w[DATA_W-1:0] = rx_dout;

    bus_out_w = '0;
    if (io.rd_en)        bus_out_w = rx_head_w;
    else if (io.stat_en) bus_out_w = status_w;
  end

  assign io.bus_out = bus_out_w;

endmodule

// File: tb/tb_io_fifo_port.sv
// Scoreboard bench for io_fifo_port: queue-based reference model, directed scenarios, then random traffic.
module tb_io_fifo_port;

  localparam int DATA_W = 8;
  localparam int BUS_W  = 16;
  localparam int DEPTH  = 4;
  localparam int SC     = 2;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  io_fifo_port_if #(.DATA_W(DATA_W), .BUS_W(BUS_W)) bus_if ();

  io_fifo_port #(
    .DATA_W(DATA_W), .BUS_W(BUS_W), .DEPTH(DEPTH), .STROBE_CYCLES(SC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus_if)
  );

  typedef struct {
    bit          rst;
    bit          in_stb;
    logic [7:0]  in_v;
    bit          rd;
    bit          st;
    bit          wr;
    logic [15:0] wdat;
    bit          ordy;
  } stim_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain queues, sticky flags and a "cycles until transmitter free" count.
  logic [7:0]  m_rx[$];
  logic [7:0]  m_tx[$];
  bit          m_rx_ovf = 0;
  bit          m_tx_ovf = 0;
  int          m_busy   = 0;
  logic [15:0] exp_bus_q[$];
  logic [7:0]  exp_chr_q[$];
  int          rise_cyc[$];
  bit          ready_lvl = 1;
  bit          mon_en    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] m_status();
    logic [15:0] s;
    s = 16'h0;
    s[0] = (m_rx.size() > 0);
    s[1] = (m_tx.size() == DEPTH);
    s[2] = m_rx_ovf;
    s[3] = (m_busy > 0);
    s[4] = m_tx_ovf;
    s[8 +: CNT_W] = CNT_W'(m_rx.size());
    return s;
  endfunction

  function automatic stim_t mk();
    stim_t s;
    s.rst = 0; s.in_stb = 0; s.in_v = 8'h0; s.rd = 0; s.st = 0;
    s.wr = 0; s.wdat = 16'h0; s.ordy = ready_lvl;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    logic [15:0] e;
    bit rx_pop, tx_start, rx_ovf_set, tx_ovf_set, clr;
    int rxn, txn;
    @(negedge clk);
    rst              = s.rst;
    bus_if.in_stb    = s.in_stb;
    bus_if.in        = s.in_v;
    bus_if.rd_en     = s.rd;
    bus_if.stat_en   = s.st;
    bus_if.wr_en     = s.wr;
    bus_if.bus_in    = s.wdat;
    bus_if.out_ready = s.ordy;
    e = 16'h0;
    if (s.rd)      e = (m_rx.size() > 0) ? {8'h00, m_rx[0]} : 16'h0;
    else if (s.st) e = m_status();
    exp_bus_q.push_back(e);
    if (s.rst) begin
      m_rx.delete(); m_tx.delete();
      m_rx_ovf = 0; m_tx_ovf = 0; m_busy = 0;
    end else begin
      rxn = m_rx.size();
      txn = m_tx.size();
      rx_pop     = s.rd && rxn > 0;
      tx_start   = (m_busy == 0) && txn > 0 && s.ordy;
      rx_ovf_set = s.in_stb && rxn == DEPTH && !rx_pop;
      tx_ovf_set = s.wr && txn == DEPTH && !tx_start;
      clr        = s.st && !s.rd;
      if (rx_pop) void'(m_rx.pop_front());
      if (s.in_stb && !rx_ovf_set) m_rx.push_back(s.in_v);
      if (m_busy > 0) m_busy--;
      if (tx_start) begin
        exp_chr_q.push_back(m_tx.pop_front());
        m_busy = SC + 1;
      end
      if (s.wr && !tx_ovf_set) m_tx.push_back(s.wdat[7:0]);
      m_rx_ovf = rx_ovf_set || (m_rx_ovf && !clr);
      m_tx_ovf = tx_ovf_set || (m_tx_ovf && !clr);
    end
  endtask

  // Bus monitor: one expected bus_out value per driven cycle.
  always begin
    @(negedge clk);
    #2;
    if (exp_bus_q.size() > 0) check("bus_out", 32'(bus_if.bus_out), 32'(exp_bus_q.pop_front()));
  end

  // Strobe monitor: character order, strobe width and minimum spacing.
  int  mcyc = 0;
  int  last_rise = -1;
  int  hi_cnt = 0;
  bit  prev_stb = 0;
  bit  aborted = 0;
  always begin
    @(negedge clk);
    #2;
    mcyc++;
    if (mon_en) begin
      if (bus_if.out_stb === 1'b1) begin
        if (!prev_stb) begin
          if (last_rise >= 0) check("stb_period_min", 32'((mcyc - last_rise) >= SC + 2), 32'd1);
          last_rise = mcyc;
          rise_cyc.push_back(mcyc);
          if (exp_chr_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_strobe: out=0x%0h, required no strobe", bus_if.out);
          end else check("out_char", 32'(bus_if.out), 32'(exp_chr_q.pop_front()));
          hi_cnt = 1; aborted = 0;
        end else hi_cnt++;
        if (rst) aborted = 1;
      end else if (prev_stb && !aborted) check("stb_width", 32'(hi_cnt), 32'(SC));
      if (rst) last_rise = -1;
      prev_stb = (bus_if.out_stb === 1'b1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    int base;
    bit seen;
    bus_if.in = '0; bus_if.in_stb = 0; bus_if.out_ready = 1; bus_if.bus_in = '0;
    bus_if.wr_en = 0; bus_if.rd_en = 0; bus_if.stat_en = 0;

    // Reset state.
    repeat (3) begin s = mk(); s.rst = 1; drive(s); end
    s = mk(); drive(s);
    mon_en = 1;
    #2;
    check("rst_out_stb", 32'(bus_if.out_stb), 32'd0);
    check("rst_out", 32'(bus_if.out), 32'd0);
    s = mk(); s.st = 1; drive(s);

    // Three characters in, status, three reads, status.
    for (int i = 0; i < 3; i++) begin s = mk(); s.in_stb = 1; s.in_v = 8'h41 + 8'(i); drive(s); end
    s = mk(); s.st = 1; drive(s);
    repeat (3) begin s = mk(); s.rd = 1; drive(s); end
    s = mk(); s.st = 1; drive(s);
    s = mk(); s.rd = 1; drive(s);

    // RX overflow and its clear by a status read.
    for (int i = 0; i < 5; i++) begin s = mk(); s.in_stb = 1; s.in_v = 8'h10 + 8'(i); drive(s); end
    s = mk(); s.st = 1; drive(s);
    repeat (4) begin s = mk(); s.rd = 1; drive(s); end
    s = mk(); s.st = 1; drive(s);
    s = mk(); s.st = 1; drive(s);

    // Single TX character, exact strobe timing.
    s = mk(); s.wr = 1; s.wdat = 16'hAB55; drive(s);
    for (int k = 0; k <= SC + 1; k++) begin
      s = mk(); s.st = 1; drive(s);
      #2;
      check("tx_stb_timing", 32'(bus_if.out_stb), 32'(k >= 1 && k <= SC));
      if (k >= 1) check("tx_out_hold", 32'(bus_if.out), 32'h55);
    end
    repeat (3) begin s = mk(); drive(s); end

    // TX overflow with out_ready low, then a back-to-back burst.
    ready_lvl = 0;
    for (int i = 0; i < 5; i++) begin s = mk(); s.wr = 1; s.wdat = 16'h00A0 + 16'(i); drive(s); end
    s = mk(); s.st = 1; drive(s);
    ready_lvl = 1;
    base = rise_cyc.size();
    repeat (4 * (SC + 2) + 6) begin s = mk(); drive(s); end
    check("burst_count", 32'(rise_cyc.size() - base), 32'd4);
    if (rise_cyc.size() - base == 4)
      for (int i = 1; i < 4; i++)
        check("burst_period", 32'(rise_cyc[base + i] - rise_cyc[base + i - 1]), 32'(SC + 2));

    // Full RX with simultaneous push and pop.
    for (int i = 0; i < 4; i++) begin s = mk(); s.in_stb = 1; s.in_v = 8'h20 + 8'(i); drive(s); end
    s = mk(); s.in_stb = 1; s.in_v = 8'h24; s.rd = 1; drive(s);
    s = mk(); s.st = 1; drive(s);
    repeat (4) begin s = mk(); s.rd = 1; drive(s); end
    s = mk(); s.rd = 1; s.in_stb = 1; s.in_v = 8'h33; drive(s);
    s = mk(); s.rd = 1; s.st = 1; drive(s);

    // Reset in the middle of a strobe discards queued TX data.
    ready_lvl = 0;
    for (int i = 0; i < 3; i++) begin s = mk(); s.wr = 1; s.wdat = 16'h0077 + 16'(i); drive(s); end
    ready_lvl = 1;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      s = mk(); drive(s);
      #2;
      seen = (bus_if.out_stb === 1'b1);
    end
    check("rst_wait_strobe", 32'(seen), 32'd1);
    s = mk(); s.rst = 1; drive(s);
    s = mk(); drive(s);
    #2;
    check("abort_out_stb", 32'(bus_if.out_stb), 32'd0);
    check("abort_out", 32'(bus_if.out), 32'd0);
    s = mk(); s.st = 1; drive(s);
    repeat (12) begin s = mk(); drive(s); end

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      s = mk();
      s.ordy   = ($urandom_range(0, 9) < 7);
      s.in_stb = ($urandom_range(0, 9) < 3);
      s.in_v   = 8'($urandom);
      s.rd     = ($urandom_range(0, 9) < 2);
      s.st     = ($urandom_range(0, 19) < 3);
      s.wr     = ($urandom_range(0, 9) < 3);
      s.wdat   = 16'($urandom);
      s.rst    = ($urandom_range(0, 199) == 0);
      ready_lvl = s.ordy;
      drive(s);
    end

    // Drain and confirm every queued character was seen.
    ready_lvl = 1;
    repeat (DEPTH * (SC + 2) + 10) begin s = mk(); drive(s); end
    #3;
    check("tx_drained", 32'(exp_chr_q.size()), 32'd0);
    @(negedge clk);
    #4;
    check("bus_drained", 32'(exp_bus_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
